// File: rtl/leb128_reader_if.sv
// ROM read bus for the LEB128 reader: byte address/request out, byte/ready back.
// The reader uses the master side; the ROM model uses the slave side.
interface leb128_reader_if;
  logic [31:0] rom_addr;
  logic        rom_read_en;
  logic [7:0]  rom_data;
  logic        rom_ready;

  modport master (output rom_addr, rom_read_en, input rom_data, rom_ready);
  modport slave  (input rom_addr, rom_read_en, output rom_data, rom_ready);
endinterface

// File: rtl/leb128_reader.sv
// LEB128 decoder that walks a byte ROM from start_addr, one byte per ROM response.
// Optional sLEB128 sign extension is built only when LEB128_SIGNED_EN is defined.
module leb128_reader #(
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [31:0]            start_addr,
  input  logic                   signed_mode,
  leb128_reader_if.master        rom,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            value,
  output logic [31:0]            next_addr
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [31:0]   cur_addr;
  logic [31:0]   acc;
  logic [31:0]   acc_nxt;
  logic [31:0]   dec_val;
  logic [2:0]    idx;
  logic [TW-1:0] tcnt;
  logic          adv;

  function automatic logic [31:0] acc_byte(input logic [31:0] a, input logic [6:0] b,
                                           input logic [2:0] i);
    logic [31:0] w;
    w = {25'd0, b};
    return a | (w << ({29'd0, i} * 32'd7));
  endfunction

`ifdef LEB128_SIGNED_EN
  logic sm_q;

  // Bit (sh-1) of the accumulator is bit 6 of the last byte, so an arithmetic
  // shift pair extends from it only when that bit is set.
  function automatic logic [31:0] sign_ext(input logic [31:0] a, input logic [2:0] i);
    logic [5:0]         sh;
    logic signed [31:0] t;
    sh = 6'd7 * ({3'd0, i} + 6'd1);
    if (sh >= 6'd32) return a;
    t = signed'(a << (6'd32 - sh));
    return t >>> (6'd32 - sh);
  endfunction
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  always_comb begin
    acc_nxt = acc_byte(acc, rom.rom_data[6:0], idx);
`ifdef LEB128_SIGNED_EN
    dec_val = sm_q ? sign_ext(acc_nxt, idx) : acc_nxt;
`else
    dec_val = acc_nxt;
`endif
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        if (rom.rom_ready) begin
          if (!rom.rom_data[7])    state_nxt = DONE;
          else if (idx == 3'd4)    state_nxt = ERR;
          else                     adv = 1'b1;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign error           = (state == ERR);
  assign rom.rom_read_en = (state == FETCH);
  // The next address is presented in the same cycle the continuation byte
  // arrives, so the ROM can answer it on the following cycle.
  assign rom.rom_addr    = (state != FETCH) ? 32'd0 :
                           adv ? cur_addr + 32'd1 : cur_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      acc       <= '0;
      idx       <= '0;
      tcnt      <= '0;
      value     <= '0;
      next_addr <= '0;
`ifdef LEB128_SIGNED_EN
      sm_q      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cur_addr <= start_addr;
          acc      <= '0;
          idx      <= '0;
          tcnt     <= '0;
`ifdef LEB128_SIGNED_EN
          sm_q     <= signed_mode;
`endif
        end
        FETCH: begin
          if (rom.rom_ready) begin
            tcnt <= '0;
            acc  <= acc_nxt;
            if (adv) begin
              cur_addr <= cur_addr + 32'd1;
              idx      <= idx + 3'd1;
            end
            if (!rom.rom_data[7]) begin
              value     <= dec_val;
              next_addr <= cur_addr + 32'd1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
